// File: rtl/aes_dec_pkg.sv
// Shared types and sizes for the AES-128 decrypt stream front-end.
package aes_dec_pkg;
    localparam int AES_BLK_W         = 128;
    localparam int AES_WORD_W        = 32;
    localparam int AES_WORDS_PER_BLK = 4;
    localparam int PIPE_LAT_DEF      = 10;

    localparam logic [1:0] LAST_WORD_IDX = 2'(AES_WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_SEND    = 2'd2
    } state_t;
endpackage

// File: rtl/aes_word_gather.sv
// Four-word shift assembler: the first word accepted ends up in [127:96].
// o_full pulses combinationally on the cycle the 4th word is being accepted.
module aes_word_gather
    import aes_dec_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic [AES_WORD_W-1:0] i_word,
    output logic [AES_BLK_W-1:0]  o_data,
    output logic [AES_BLK_W-1:0]  o_next,
    output logic                  o_full
);
    logic [AES_BLK_W-1:0] r_data;
    logic [1:0]           r_idx;

    assign o_next = {r_data[AES_BLK_W-AES_WORD_W-1:0], i_word};
    assign o_full = i_en & (r_idx == LAST_WORD_IDX);
    assign o_data = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_en) begin
            r_data <= o_next;
            r_idx  <= r_idx + 2'd1;
        end
    end
endmodule

// File: rtl/aes_dec_stream_ctrl.sv
// Stream front-end for the pipelined AES-128 decrypt core, one block in flight.
// Define AES_DEC_CTRL_PERF_EN to make blk_count a live delivered-block counter.
module aes_dec_stream_ctrl
    import aes_dec_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AES_WORD_W-1:0] in_word,
    input  logic                  in_is_key,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [AES_BLK_W-1:0]  aes_cipher,
    output logic [AES_BLK_W-1:0]  aes_key,
    input  logic [AES_BLK_W-1:0]  aes_plain,
    output logic [AES_WORD_W-1:0] out_word,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_nokey,
    output logic [31:0]           blk_count
);
    localparam logic [7:0] LAT_LAST = 8'(PIPE_LAT - 1);

    state_t               r_state;
    logic [AES_BLK_W-1:0] r_key;
    logic [AES_BLK_W-1:0] r_out_buf;
    logic                 r_key_loaded;
    logic [7:0]           r_lat_cnt;
    logic [1:0]           r_out_idx;
    logic                 r_out_valid;
    logic                 r_err_nokey;

    logic                 w_acc;
    logic                 w_out_hs;
    logic                 w_key_full;
    logic                 w_ct_full;
    logic [AES_BLK_W-1:0] w_key_next;
    logic [AES_BLK_W-1:0] w_unused_key_data;
    logic [AES_BLK_W-1:0] w_unused_ct_next;

    assign in_ready = (r_state == S_COLLECT) & ~rst;
    assign w_acc    = in_valid & in_ready;
    assign w_out_hs = r_out_valid & out_ready;

    // Key words stay in the staging gather until complete, so the core never sees a partial key.
    aes_word_gather u_key_gather (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_acc & in_is_key),
        .i_word (in_word),
        .o_data (w_unused_key_data),
        .o_next (w_key_next),
        .o_full (w_key_full)
    );

    aes_word_gather u_ct_gather (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_acc & ~in_is_key),
        .i_word (in_word),
        .o_data (aes_cipher),
        .o_next (w_unused_ct_next),
        .o_full (w_ct_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_COLLECT;
            r_key        <= '0;
            r_key_loaded <= 1'b0;
            r_lat_cnt    <= '0;
            r_out_buf    <= '0;
            r_out_idx    <= '0;
            r_out_valid  <= 1'b0;
            r_err_nokey  <= 1'b0;
        end else begin
            r_err_nokey <= 1'b0;
            if (w_key_full) begin
                r_key        <= w_key_next;
                r_key_loaded <= 1'b1;
            end
            case (r_state)
                S_COLLECT: begin
                    if (w_ct_full) begin
                        if (r_key_loaded) begin
                            r_state   <= S_WAIT;
                            r_lat_cnt <= '0;
                        end else begin
                            r_err_nokey <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt + 8'd1;
                    if (r_lat_cnt == LAT_LAST) begin
                        r_out_buf   <= aes_plain;
                        r_out_idx   <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Buffer shifts left so the head word is always [127:96].
                    if (w_out_hs) begin
                        r_out_buf <= {r_out_buf[AES_BLK_W-AES_WORD_W-1:0], {AES_WORD_W{1'b0}}};
                        r_out_idx <= r_out_idx + 2'd1;
                        if (r_out_idx == LAST_WORD_IDX) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_COLLECT;
                        end
                    end
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    assign aes_key   = r_key;
    assign out_word  = r_out_buf[AES_BLK_W-1 -: AES_WORD_W];
    assign out_last  = r_out_valid & (r_out_idx == LAST_WORD_IDX);
    assign out_valid = r_out_valid;
    assign err_nokey = r_err_nokey;

`ifdef AES_DEC_CTRL_PERF_EN
    logic [31:0] r_blk_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_count <= '0;
        end else if (w_out_hs && (r_out_idx == LAST_WORD_IDX)) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign blk_count = r_blk_count;
`else
    assign blk_count = 32'h0;
`endif
endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// Directed bench for aes_dec_stream_ctrl with a fixed-latency stand-in for the AES core.
module tb_aes_dec_stream_ctrl;
    localparam int PIPE_LAT = 10;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_DEC_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic         clk, rst;
    logic [31:0]  in_word;
    logic         in_is_key, in_valid, in_ready;
    logic [127:0] aes_cipher, aes_key, aes_plain;
    logic [31:0]  out_word;
    logic         out_last, out_valid, out_ready, err_nokey;
    logic [31:0]  blk_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    aes_dec_stream_ctrl #(.PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_is_key(in_is_key),
        .in_valid(in_valid), .in_ready(in_ready), .aes_cipher(aes_cipher),
        .aes_key(aes_key), .aes_plain(aes_plain), .out_word(out_word),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .err_nokey(err_nokey), .blk_count(blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: real FIPS-197 answer for the known vector, cipher^key otherwise.
    // Output is valid PIPE_LAT edges after the inputs settle, and garbage one edge earlier.
    function automatic logic [127:0] core_f(input logic [127:0] c, input logic [127:0] k);
        if (c == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        return c ^ k;
    endfunction

    logic [127:0] cpipe [PIPE_LAT-1];
    always @(posedge clk) begin
        cpipe[0] <= core_f(aes_cipher, aes_key);
        for (int i = 1; i < PIPE_LAT-1; i++) cpipe[i] <= cpipe[i-1];
    end
    assign aes_plain = cpipe[PIPE_LAT-2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] w, input logic k);
        int n = 0;
        in_word = w; in_is_key = k; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("in_ready_timeout", in_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_block(input logic [127:0] k, input logic [127:0] c, input bit sk, input bit ilv);
        if (ilv) begin
            for (int i = 0; i < 4; i++) begin
                send_word(k[127-32*i -: 32], 1'b1);
                send_word(c[127-32*i -: 32], 1'b0);
            end
        end else begin
            if (sk) for (int i = 0; i < 4; i++) send_word(k[127-32*i -: 32], 1'b1);
            for (int i = 0; i < 4; i++) send_word(c[127-32*i -: 32], 1'b0);
        end
    endtask

    task automatic recv_word(input logic [31:0] w, input logic last, input string nm);
        int n = 0;
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_word"}, out_word, w);
        chk({nm, "_last"}, out_last, last);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic recv_block(input logic [127:0] pt, input bit chk_lat, input string nm);
        int n = 0;
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        // out_valid is seen right after the PIPE_LAT-th edge past the accepting edge
        if (chk_lat) chk({nm, "_latency"}, cyc - acc_cyc, PIPE_LAT);
        for (int i = 0; i < 4; i++) recv_word(pt[127-32*i -: 32], i == 3, nm);
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        bit           send_key;
        bit           ilv;
    } vec_t;

    vec_t vt [5];

    initial begin
        logic [127:0] nk;
        bit           flag;
        int           n;

        vt[0] = '{FIPS_KEY, FIPS_CT, FIPS_PT, 1'b1, 1'b0};
        vt[1] = '{128'h0, 128'hdeadbeef0123456789abcdefcafef00d,
                  128'hdeadbeef0123456789abcdefcafef00d, 1'b1, 1'b0};
        vt[2] = '{FIPS_KEY, FIPS_CT, FIPS_PT, 1'b1, 1'b1};
        vt[3] = '{128'hffffffff00000000ffffffff00000000, 128'h12345678123456781234567812345678,
                  128'hedcba98712345678edcba98712345678, 1'b1, 1'b0};
        vt[4] = '{128'hffffffff00000000ffffffff00000000, 128'h00000001000000020000000300000004,
                  128'hfffffffe00000002fffffffc00000004, 1'b0, 1'b0};
        nk = 128'h0f0e0d0c0b0a09080706050403020100;

        rst = 1'b1; in_word = '0; in_is_key = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cipher", aes_cipher, 0);
        chk("rst_key", aes_key, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err_nokey, 0);
        chk("rst_blk_count", blk_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Ciphertext with no key: one err pulse, block dropped
        for (int i = 0; i < 4; i++) send_word(FIPS_CT[127-32*i -: 32], 1'b0);
        chk("nokey_err_pulse", err_nokey, 1);
        chk("nokey_in_ready", in_ready, 1);
        @(negedge clk);
        chk("nokey_err_clear", err_nokey, 0);
        flag = 1'b0;
        repeat (PIPE_LAT + 6) begin
            @(negedge clk);
            if (out_valid || err_nokey || !in_ready) flag = 1'b1;
        end
        chk("nokey_quiet", flag, 0);

        for (int v = 0; v < 5; v++) begin
            send_block(vt[v].key, vt[v].ct, vt[v].send_key, vt[v].ilv);
            recv_block(vt[v].pt, 1'b1, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_key", v), aes_key, vt[v].key);
        end

        // Backpressure: head word held for 20 cycles, input closed
        out_ready = 1'b0;
        send_block(FIPS_KEY, FIPS_CT, 1'b1, 1'b0);
        n = 0;
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        flag = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || out_word !== 32'h00112233 || in_ready !== 1'b0 || out_last) flag = 1'b0;
        end
        chk("bp_hold", flag, 1);
        chk("bp_word", out_word, 32'h00112233);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) recv_word(FIPS_PT[127-32*i -: 32], 1'b0, "bp");

        // in_valid during the final output handshake: taken one cycle later, exactly once
        in_word = nk[127:96]; in_is_key = 1'b1; in_valid = 1'b1;
        chk("sim_last", out_last, 1);
        chk("sim_word", out_word, 32'hccddeeff);
        chk("sim_in_blocked", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("sim_out_done", out_valid, 0);
        chk("sim_in_open", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 4; i++) send_word(nk[127-32*i -: 32], 1'b1);
        chk("sim_key", aes_key, nk);
        chk("blk_count_6", blk_count, 6 * PERF);

        // Reset while waiting on the core (lat_cnt = 5)
        send_block(FIPS_KEY, FIPS_CT, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        chk("wrst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("wrst_key", aes_key, 0);
        chk("wrst_cipher", aes_cipher, 0);
        chk("wrst_out_word", out_word, 0);
        chk("wrst_out_last", out_last, 0);
        chk("wrst_out_valid", out_valid, 0);
        chk("wrst_err", err_nokey, 0);
        chk("wrst_blk_count", blk_count, 0);
        rst = 1'b0;
        flag = 1'b0;
        repeat (PIPE_LAT + 5) begin
            @(negedge clk);
            if (out_valid) flag = 1'b1;
        end
        chk("wrst_no_output", flag, 0);
        for (int i = 0; i < 4; i++) send_word(FIPS_CT[127-32*i -: 32], 1'b0);
        chk("wrst_nokey_err", err_nokey, 1);

        // Three blocks back to back
        send_block(FIPS_KEY, FIPS_CT, 1'b1, 1'b0);
        recv_block(FIPS_PT, 1'b1, "b2b0");
        send_block(FIPS_KEY, FIPS_CT, 1'b0, 1'b0);
        recv_block(FIPS_PT, 1'b1, "b2b1");
        send_block(FIPS_KEY, 128'h0, 1'b0, 1'b0);
        recv_block(FIPS_KEY, 1'b1, "b2b2");
        chk("b2b_blk_count", blk_count, 3 * PERF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
